// File: rtl/v_fsm_pkg.sv
// Shared encodings for the v_fsm_1 sequencer/checker: controller states,
// pass phases, and the target FSM state codes used for bench-side prediction.
package v_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } ctrl_state_t;

    // Each pass is three cycles: x1 is presented only in P0.
    localparam logic [1:0] P0 = 2'd0;
    localparam logic [1:0] P1 = 2'd1;
    localparam logic [1:0] P2 = 2'd2;

    // Target FSM states; S1 is the reset state and drives outp=1.
    localparam logic [1:0] S1 = 2'd0;
    localparam logic [1:0] S2 = 2'd1;
    localparam logic [1:0] S3 = 2'd2;
    localparam logic [1:0] S4 = 2'd3;

endpackage

// File: rtl/v_fsm_seq.sv
// Drives one v_fsm_1 instance through a programmed run of 3-cycle passes,
// captures its output once per pass and flags the first deviation.
module v_fsm_seq
    import v_fsm_pkg::*;
#(
    parameter int MAX_PASS = 8,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [MAX_PASS-1:0] cmd,
    input  logic [LEN_W-1:0]    len,
    output logic                busy,
    output logic                done,
    output logic [MAX_PASS-1:0] result,
    output logic                err,
    output logic [LEN_W-1:0]    err_pass,
    output logic                fsm_reset,
    output logic                fsm_x1,
    input  logic                fsm_outp
);

    localparam int PASS_W = (MAX_PASS > 1) ? $clog2(MAX_PASS) : 1;

    ctrl_state_t         state;
    logic [1:0]          phase;
    logic [LEN_W-1:0]    pass;
    logic [MAX_PASS-1:0] cmd_q;
    logic [LEN_W-1:0]    len_q;

    logic [PASS_W-1:0]   pidx;
    logic [PASS_W-1:0]   pidx_nx;
    logic                last_pass;
    logic                exp_outp;
    logic [LEN_W-1:0]    len_clamp;

    assign pidx      = pass[PASS_W-1:0];
    assign pidx_nx   = pidx + PASS_W'(1);
    assign last_pass = (pass == len_q - LEN_W'(1));
    assign len_clamp = (len > LEN_W'(MAX_PASS)) ? LEN_W'(MAX_PASS) : len;

    // Target leaves reset in S1 (outp=1); a pass with x1=1 walks S3,S4 and
    // holds outp high for phases 1-2, then every pass restarts from S2 (outp=0).
    always_comb begin
        exp_outp = 1'b0;
        if (phase == P0)
            exp_outp = (pass == '0);
        else
            exp_outp = cmd_q[pidx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            phase     <= P0;
            pass      <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            err       <= 1'b0;
            err_pass  <= '0;
            fsm_x1    <= 1'b0;
            fsm_reset <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    busy      <= 1'b0;
                    fsm_x1    <= 1'b0;
                    fsm_reset <= 1'b1;
                    if (start) begin
                        cmd_q    <= cmd;
                        len_q    <= len_clamp;
                        result   <= '0;
                        err      <= 1'b0;
                        err_pass <= '0;
                        phase    <= P0;
                        pass     <= '0;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy      <= 1'b1;
                            fsm_reset <= 1'b0;
                            fsm_x1    <= cmd[0];
                        end
                    end
                end

                RUN: begin
                    if ((fsm_outp != exp_outp) && !err) begin
                        err      <= 1'b1;
                        err_pass <= pass;
                    end
                    if (phase == P2)
                        result[pidx] <= fsm_outp;

                    // Abort has priority over normal completion so it always flags err.
                    if (abort) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm_reset <= 1'b1;
                        fsm_x1    <= 1'b0;
                        err       <= 1'b1;
                        if (!err)
                            err_pass <= pass;
                    end else if ((phase == P2) && last_pass) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        fsm_reset <= 1'b1;
                        fsm_x1    <= 1'b0;
                    end else if (phase == P2) begin
                        phase  <= P0;
                        pass   <= pass + LEN_W'(1);
                        fsm_x1 <= cmd_q[pidx_nx];
                    end else begin
                        phase  <= phase + 2'd1;
                        fsm_x1 <= 1'b0;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    fsm_x1    <= 1'b0;
                    fsm_reset <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    fsm_x1    <= 1'b0;
                    fsm_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v_fsm_seq.sv
// Directed bench for v_fsm_seq with a behavioural v_fsm_1 target attached.
module tb_v_fsm_seq;
    import v_fsm_pkg::*;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] cmd;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       err;
    logic [3:0] err_pass;
    logic       fsm_reset;
    logic       fsm_x1;
    logic       fsm_outp;

    int vec_cnt = 0;
    int err_cnt = 0;

    v_fsm_seq #(.MAX_PASS(8), .LEN_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cmd       (cmd),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err),
        .err_pass  (err_pass),
        .fsm_reset (fsm_reset),
        .fsm_x1    (fsm_x1),
        .fsm_outp  (fsm_outp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target model: S1 -x1-> S3 -> S4 -> S2; S1/S2/S4 go to S3 on x1, else S2.
    logic [1:0] tst;
    logic       force0;
    always @(posedge clk) begin
        if (fsm_reset) tst <= S1;
        else begin
            case (tst)
                S3:      tst <= S4;
                default: tst <= fsm_x1 ? S3 : S2;
            endcase
        end
    end
    assign fsm_outp = force0 ? 1'b0 : (tst != S2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents start for one edge, then scrambles cmd/len to prove they were latched.
    task automatic start_run(input logic [7:0] c, input logic [3:0] l);
        start = 1'b1;
        cmd   = c;
        len   = l;
        tick();
        start = 1'b0;
        cmd   = 8'($urandom);
        len   = 4'($urandom);
    endtask

    // Called in the first cycle after start; returns with done sampled high (or bound expired).
    task automatic wait_done(input string tag, input int exp_lat, input int exp_busy);
        int n;
        int bcnt;
        n    = 1;
        bcnt = 0;
        while (!done && n < 200) begin
            bcnt += int'(busy);
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_busy"}, bcnt, exp_busy);
    endtask

    localparam logic [11:0] OUTP_T1 = 12'b1110_0001_1000; // MSB = first RUN cycle
    localparam logic [11:0] X1_T1   = 12'b1000_0010_0000;

    initial begin
        logic [11:0] ot;
        logic [11:0] xt;
        ot     = OUTP_T1;
        xt     = X1_T1;
        reset  = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        cmd    = '0;
        len    = '0;
        force0 = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_errp", err_pass, 4'd0);
        chk("rst_result", result, 8'h00);
        chk("rst_x1", fsm_x1, 1'b0);
        chk("rst_fsmrst", fsm_reset, 1'b1);
        tick();

        // T1: len=4 cmd=0101, correct target, cycle-by-cycle waveform
        start_run(8'b0000_0101, 4'd4);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("t1_outp%0d", i), fsm_outp, ot[11-i]);
            chk($sformatf("t1_x1_%0d", i), fsm_x1, xt[11-i]);
            chk($sformatf("t1_busy%0d", i), busy, 1'b1);
            chk($sformatf("t1_done%0d", i), done, 1'b0);
            tick();
        end
        chk("t1_done", done, 1'b1);
        chk("t1_busyd", busy, 1'b0);
        chk("t1_result", result, 8'h05);
        chk("t1_err", err, 1'b0);
        tick();
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_fsmrst", fsm_reset, 1'b1);
        tick();
        chk("t1_result_hold", result, 8'h05);

        // T2: same run, target outp stuck at 0 through pass 2
        start_run(8'b0000_0101, 4'd4);
        for (int i = 1; i <= 12; i++) begin
            force0 = (i >= 7 && i <= 9);
            tick();
        end
        force0 = 1'b0;
        chk("t2_done", done, 1'b1);
        chk("t2_err", err, 1'b1);
        chk("t2_errp", err_pass, 4'd2);
        chk("t2_result", result, 8'h01);
        tick();
        tick();
        chk("t2_err_hold", err, 1'b1);
        chk("t2_errp_hold", err_pass, 4'd2);

        // T3: len=0 goes straight to DONE and clears the previous error
        start_run(8'hFF, 4'd0);
        chk("t3_done", done, 1'b1);
        chk("t3_busy", busy, 1'b0);
        chk("t3_result", result, 8'h00);
        chk("t3_err", err, 1'b0);
        chk("t3_errp", err_pass, 4'd0);
        tick();
        tick();

        // T4: len=12 clamps to 8 passes
        start_run(8'hA5, 4'd12);
        wait_done("t4", 25, 24);
        chk("t4_result", result, 8'hA5);
        chk("t4_err", err, 1'b0);
        tick();
        tick();

        // T5: abort in 5th RUN cycle, then start during DONE must be ignored
        start_run(8'b0000_0011, 4'd4);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_done", done, 1'b1);
        chk("t5_err", err, 1'b1);
        chk("t5_errp", err_pass, 4'd1);
        chk("t5_result", result, 8'h01);
        start = 1'b1;
        cmd   = 8'h0F;
        len   = 4'd4;
        tick();
        start = 1'b0;
        chk("t5_start_in_done", busy, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_idle_abort_busy", busy, 1'b0);
        chk("t5_idle_abort_res", result, 8'h01);
        tick();

        // T6: abort coincident with last-pass completion, len=1
        start_run(8'h01, 4'd1);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t6_done", done, 1'b1);
        chk("t6_err", err, 1'b1);
        chk("t6_errp", err_pass, 4'd0);
        tick();

        // T7: reset mid-run, no done pulse, then a clean run
        start_run(8'b0000_0101, 4'd4);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t7_busy", busy, 1'b0);
        chk("t7_fsmrst", fsm_reset, 1'b1);
        chk("t7_done", done, 1'b0);
        begin
            int dcnt;
            dcnt = 0;
            for (int i = 0; i < 15; i++) begin
                dcnt += int'(done) + int'(busy);
                tick();
            end
            chk("t7_quiet", dcnt, 0);
        end
        start_run(8'b0000_0101, 4'd4);
        wait_done("t7_rerun", 13, 12);
        chk("t7_result", result, 8'h05);
        chk("t7_err", err, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
